btn_conditioner: RTL and testbench

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_conditioner.sv | 158 +++++++++++++++
 tb/tb_btn_conditioner.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronize, debounce and decode stopwatch keys into tick-timed events
// Ports: clk, rst (sync, active-high); key_ssr_n, key_lap_n (raw, active-low), sw_view (raw, active-high);
//        tick (1-clk pulse every CLK_HZ/TICK_HZ clk), ssr_short, ssr_long, lap_press (1-clk pulses),
//        view_lvl (debounced level).
// Macro BTN_LONG_PRESS_EN: enables the LONG state and ssr_long; otherwise ssr_long is tied to 0.
module btn_conditioner #(
   parameter int CLK_HZ          = 50000000,
   parameter int TICK_HZ         = 100,
   parameter int DEB_TICKS       = 2,
   parameter int SHORT_MIN_TICKS = 5,
   parameter int LONG_TICKS      = 100
) (
   input  logic clk,
   input  logic rst,
   input  logic key_ssr_n,
   input  logic key_lap_n,
   input  logic sw_view,
   output logic tick,
   output logic ssr_short,
   output logic ssr_long,
   output logic lap_press,
   output logic view_lvl
);
   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int CW  = $clog2(DIV + 1);
   localparam int DW  = $clog2(DEB_TICKS + 1);
`ifdef BTN_LONG_PRESS_EN
   localparam int HMAX = LONG_TICKS;
`else
   localparam int HMAX = SHORT_MIN_TICKS;
`endif
   localparam int HW = $clog2(HMAX + 1);
   // raw order {view, lap_n, ssr_n}; released raw value is 3'b011
   localparam logic [2:0] REL = 3'b011;

   logic [2:0]    s1, s2, smp, deb, acc;
   logic [DW-1:0] dcnt [3];
   logic [CW-1:0] cnt;
   logic [1:0]    armed, rise;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= REL;
         s2 <= REL;
      end else begin
         s1 <= {sw_view, key_lap_n, key_ssr_n};
         s2 <= s1;
      end
   end

   // active-high "pressed / on" view of the synchronized inputs
   assign smp = s2 ^ REL;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         tick <= cnt == CW'(DIV - 1);
         cnt  <= cnt == CW'(DIV - 1) ? '0 : cnt + 1'b1;
      end
   end

   // a sample equal to the current level restarts the run of disagreeing samples
   for (genvar i = 0; i < 3; i++) begin : g_deb
      assign acc[i] = tick && smp[i] != deb[i] && dcnt[i] == DW'(DEB_TICKS - 1);
      always_ff @(posedge clk) begin
         if (rst) begin
            deb[i]  <= 1'b0;
            dcnt[i] <= '0;
         end else if (tick) begin
            deb[i]  <= acc[i] ? smp[i] : deb[i];
            dcnt[i] <= (smp[i] == deb[i] || acc[i]) ? '0 : dcnt[i] + 1'b1;
         end
      end
   end

   // a key arms only once it has been seen released while debounced released,
   // so a key held through reset cannot fire until it is let go and pressed again
   always_ff @(posedge clk) begin
      if (rst) armed <= '0;
      else     armed <= armed | ({2{tick}} & ~smp[1:0] & ~deb[1:0]);
   end

   assign rise     = acc[1:0] & smp[1:0] & armed;
   assign view_lvl = deb[2];

   always_ff @(posedge clk) begin
      if (rst) lap_press <= 1'b0;
      else     lap_press <= rise[1];
   end

`ifdef BTN_LONG_PRESS_EN
   typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;
`else
   typedef enum logic [1:0] {IDLE, HELD} state_t;
`endif

   state_t        st, st_n;
   logic [HW-1:0] hold, hold_n;
   logic          short_n;
`ifdef BTN_LONG_PRESS_EN
   logic          long_n;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= IDLE;
         hold      <= '0;
         ssr_short <= 1'b0;
      end else begin
         st        <= st_n;
         hold      <= hold_n;
         ssr_short <= short_n;
      end
   end

`ifdef BTN_LONG_PRESS_EN
   always_ff @(posedge clk) begin
      if (rst) ssr_long <= 1'b0;
      else     ssr_long <= long_n;
   end
`else
   assign ssr_long = 1'b0;
`endif

   always_comb begin
      st_n    = st;
      hold_n  = hold;
      short_n = 1'b0;
`ifdef BTN_LONG_PRESS_EN
      long_n  = 1'b0;
`endif
      case (st)
         IDLE: if (rise[0]) begin
            st_n   = HELD;
            hold_n = '0;
         end
         HELD: if (!deb[0]) begin
            st_n    = IDLE;
            short_n = hold >= HW'(SHORT_MIN_TICKS);
`ifdef BTN_LONG_PRESS_EN
         end else if (hold == HW'(LONG_TICKS)) begin
            st_n   = LONG;
            long_n = 1'b1;
         end else if (tick) begin
            hold_n = hold + 1'b1;
         end
         LONG: if (!deb[0]) st_n = IDLE;
`else
         end else if (tick && hold != HW'(HMAX)) begin
            hold_n = hold + 1'b1;
         end
`endif
         default: st_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed, table-driven check of btn_conditioner at a 10-clk tick
module tb_btn_conditioner;
   logic clk = 1'b0, rst = 1'b1;
   logic key_ssr_n = 1'b1, key_lap_n = 1'b1, sw_view = 1'b0;
   logic tick, ssr_short, ssr_long, lap_press, view_lvl;
   int   ntests = 0, nfail = 0;
   int   n_short = 0, n_long = 0, n_lap = 0;

   btn_conditioner #(
      .CLK_HZ(1000), .TICK_HZ(100), .DEB_TICKS(2), .SHORT_MIN_TICKS(5), .LONG_TICKS(20)
   ) dut (
      .clk(clk), .rst(rst), .key_ssr_n(key_ssr_n), .key_lap_n(key_lap_n), .sw_view(sw_view),
      .tick(tick), .ssr_short(ssr_short), .ssr_long(ssr_long), .lap_press(lap_press),
      .view_lvl(view_lvl)
   );

   always #5 clk = ~clk;

   // one-clk pulses: the number of high cycles equals the number of events
   always @(negedge clk) begin
      n_short += int'(ssr_short);
      n_long  += int'(ssr_long);
      n_lap   += int'(lap_press);
   end

   typedef struct {
      string name;
      int    ssr_len;
      int    lap_len;
      int    e_short;
      int    e_long;
      int    e_lap;
   } vec_t;

   vec_t v [6];

   task automatic chk(input string nm, input int act, input int exp);
      ntests++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic press(input int a, input int b);
      int m = a > b ? a : b;
      if (a > 0) key_ssr_n = 1'b0;
      if (b > 0) key_lap_n = 1'b0;
      for (int k = 0; k < m; k++) begin
         @(negedge clk);
         if (k + 1 == a) key_ssr_n = 1'b1;
         if (k + 1 == b) key_lap_n = 1'b1;
      end
      repeat (100) @(negedge clk);
   endtask

   initial begin
      int s0, l0, p0;
      v[0] = '{"ssr_100",       100,   0, 1, 0, 0};
      v[1] = '{"ssr_30",         30,   0, 0, 0, 0};
      v[2] = '{"lap_50",          0,  50, 0, 0, 1};
      v[3] = '{"ssr_lap_100",   100, 100, 1, 0, 1};
`ifdef BTN_LONG_PRESS_EN
      v[4] = '{"ssr_300",       300,   0, 0, 1, 0};
`else
      v[4] = '{"ssr_300_nolong", 300,  0, 1, 0, 0};
`endif
      v[5] = '{"ssr_60",         60,   0, 1, 0, 0};

      repeat (5) @(negedge clk);
      chk("rst_tick", int'(tick), 0);
      chk("rst_short", int'(ssr_short), 0);
      chk("rst_long", int'(ssr_long), 0);
      chk("rst_lap", int'(lap_press), 0);
      chk("rst_view", int'(view_lvl), 0);
      rst = 1'b0;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         chk($sformatf("tick_clk%0d", c), int'(tick), int'(c % 10 == 0));
      end
      chk("idle_short", n_short, 0);
      chk("idle_long", n_long, 0);
      chk("idle_lap", n_lap, 0);

      for (int i = 0; i < 6; i++) begin
         s0 = n_short; l0 = n_long; p0 = n_lap;
         press(v[i].ssr_len, v[i].lap_len);
         chk({v[i].name, "_short"}, n_short - s0, v[i].e_short);
         chk({v[i].name, "_long"}, n_long - l0, v[i].e_long);
         chk({v[i].name, "_lap"}, n_lap - p0, v[i].e_lap);
      end

      // key toggling every tick never gives two agreeing samples
      s0 = n_short; l0 = n_long;
      for (int k = 0; k < 12; k++) begin
         key_ssr_n = k[0];
         repeat (10) @(negedge clk);
      end
      key_ssr_n = 1'b1;
      repeat (100) @(negedge clk);
      chk("bounce_short", n_short - s0, 0);
      chk("bounce_long", n_long - l0, 0);

      sw_view = 1'b1;
      repeat (60) @(negedge clk);
      chk("view_on", int'(view_lvl), 1);
      sw_view = 1'b0;
      repeat (60) @(negedge clk);
      chk("view_off", int'(view_lvl), 0);

      // lap key held through reset release
      rst = 1'b1;
      key_lap_n = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      p0 = n_lap;
      repeat (100) @(negedge clk);
      chk("lap_held_rst", n_lap - p0, 0);
      key_lap_n = 1'b1;
      repeat (50) @(negedge clk);
      chk("lap_release", n_lap - p0, 0);
      press(0, 50);
      chk("lap_repress", n_lap - p0, 1);

      // reset in the middle of an ssr hold
      s0 = n_short; l0 = n_long;
      key_ssr_n = 1'b0;
      repeat (80) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (50) @(negedge clk);
      key_ssr_n = 1'b1;
      repeat (100) @(negedge clk);
      chk("midhold_rst_short", n_short - s0, 0);
      chk("midhold_rst_long", n_long - l0, 0);

      s0 = n_short;
      press(100, 0);
      chk("after_rst_short", n_short - s0, 1);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule
